// File: rtl/wra_rd_arbiter.sv
// Round-robin arbiter with burst lock for the shared WRA feature-memory read port.
// Issues one registered read per cycle and routes returned words back by tag.
module wra_rd_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 512,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_vld,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]        req_lock,
  output logic [NREQ-1:0]        req_rdy,
  output logic [NREQ-1:0]        rsp_vld,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   WRA_Rd_en,
  output logic [ADDR_W-1:0]      WRA_Address,
  input  logic [DATA_W-1:0]      WRA_FeatureData,
  output logic                   busy
);

  localparam int          IDW = $clog2(NREQ);
  localparam int unsigned NR  = NREQ;
  localparam int unsigned LAT = RD_LAT;

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    lock_id;
  logic              lock_vld;
  logic              lock_hit;
  logic [IDW-1:0]    gnt_id;
  logic              gnt_vld;
  logic [IDW-1:0]    ptr_inc;
  logic [ADDR_W-1:0] gnt_addr;
  logic [RD_LAT-1:0] tag_v;
  logic [IDW-1:0]    tag_id [RD_LAT];
  logic [NREQ-1:0]   rsp_onehot;

  // Owner keeps the port only while it still asserts both valid and lock.
  assign lock_hit = lock_vld && req_vld[lock_id] && req_lock[lock_id];

  always_comb begin
    logic [IDW:0] idx;
    idx     = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    if (lock_hit) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id;
    end else begin
      for (int unsigned k = 0; k < NR; k++) begin
        idx = {1'b0, ptr} + (IDW+1)'(k);
        if (idx >= (IDW+1)'(NR)) idx = idx - (IDW+1)'(NR);
        if (!gnt_vld && req_vld[idx[IDW-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_id  = idx[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    if (gnt_vld) req_rdy[gnt_id] = 1'b1;
  end

  always_comb begin
    gnt_addr = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (gnt_id == IDW'(k)) gnt_addr = req_addr[k*ADDR_W +: ADDR_W];
    end
  end

  assign ptr_inc = (gnt_id == IDW'(NR - 1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      lock_vld    <= 1'b0;
      lock_id     <= '0;
      WRA_Rd_en   <= 1'b0;
      WRA_Address <= '0;
    end else begin
      WRA_Rd_en <= gnt_vld;
      if (gnt_vld) begin
        WRA_Address <= gnt_addr;
        if (req_lock[gnt_id]) begin
          lock_vld <= 1'b1;
          lock_id  <= gnt_id;
        end else begin
          lock_vld <= 1'b0;
          ptr      <= ptr_inc;
        end
      end else begin
        lock_vld <= 1'b0;
      end
    end
  end

  // Stage 0 lines up with WRA_Rd_en; the last stage lines up with valid data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int unsigned s = 0; s < LAT; s++) tag_id[s] <= '0;
    end else begin
      tag_v[0]  <= gnt_vld;
      tag_id[0] <= gnt_id;
      for (int unsigned s = 1; s < LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  always_comb begin
    rsp_onehot = '0;
    if (tag_v[RD_LAT-1]) rsp_onehot[tag_id[RD_LAT-1]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld  <= '0;
      rsp_data <= '0;
    end else begin
      rsp_vld <= rsp_onehot;
      if (tag_v[RD_LAT-1]) rsp_data <= WRA_FeatureData;
    end
  end

  assign busy = (|req_vld) | (|tag_v);

endmodule
